// File: rtl/dtw_result_arbiter.sv
// dtw_result_arbiter
//   Packet-atomic round-robin arbiter. Connects NUM_CORES DTW compute cores to the single
//   write port of the M00 AXI-Stream result FIFO. A core that wins arbitration keeps the FIFO
//   for exactly WORDS_PER_PACKET words. As a result, every TLAST-delimited output packet
//   carries the results of one core only.
//
//   Handshake inside a packet is purely combinational: the granted core sees ready whenever
//   the FIFO has room. A word moves on every cycle where that core also holds valid.
//   Between packets there is one IDLE cycle. In that cycle the next owner is chosen and
//   registered.

module dtw_result_arbiter #(
    parameter int NUM_CORES            = 4,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int WORDS_PER_PACKET     = 8,
    parameter int PKT_CNT_WIDTH        = 16
) (
    input  logic                                      M_AXIS_ACLK,
    input  logic                                      M_AXIS_ARESETN,
    input  logic                                      enable,
    input  logic [NUM_CORES-1:0]                      core_res_valid,
    input  logic [NUM_CORES*C_S_AXIS_TDATA_WIDTH-1:0] core_res_data,
    output logic [NUM_CORES-1:0]                      core_res_ready,
    output logic                                      dtw_fifo_wren,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]           dtw_fifo_din,
    input  logic                                      dtw_fifo_full,
    output logic [$clog2(NUM_CORES)-1:0]              grant_idx,
    output logic                                      busy,
    output logic [PKT_CNT_WIDTH-1:0]                  pkt_count
);

    localparam int GW        = $clog2(NUM_CORES);
    localparam int WC_W      = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
    localparam int W         = C_S_AXIS_TDATA_WIDTH;

    localparam logic [WC_W-1:0] LAST_WORD  = WC_W'(WORDS_PER_PACKET - 1);
    localparam logic [GW-1:0]   LAST_CORE  = GW'(NUM_CORES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Registered state
    state_t                  state;
    logic [GW-1:0]           last_grant;
    logic [WC_W-1:0]         word_cnt;

    // Next-state values
    state_t                  state_nxt;
    logic [GW-1:0]           grant_nxt;
    logic [GW-1:0]           last_nxt;
    logic [WC_W-1:0]         word_cnt_nxt;
    logic [PKT_CNT_WIDTH-1:0] pkt_count_nxt;

    // Arbitration and handshake helpers
    logic                    pick_found;
    logic [GW-1:0]           pick_idx;
    logic                    xfer;

    // Round-robin search. It starts one past the last completed grant and wraps, so that
    // core is the last to be considered for the next packet.
    always_comb begin
        logic [GW-1:0] cand;
        // NOTE: every variable written here gets a default before any branch. A path that
        // leaves one unassigned would infer a latch.
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_CORES);
            if (!pick_found && core_res_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Zero-latency datapath: route the granted core's word to the FIFO while in XFER.
    always_comb begin
        core_res_ready = '0;
        dtw_fifo_wren  = 1'b0;
        dtw_fifo_din   = '0;
        busy           = 1'b0;
        xfer           = 1'b0;
        if (state == XFER) begin
            busy                      = 1'b1;
            core_res_ready[grant_idx] = !dtw_fifo_full;
            xfer                      = core_res_valid[grant_idx] && !dtw_fifo_full;
            dtw_fifo_wren             = xfer;
            dtw_fifo_din              = core_res_data[int'(grant_idx) * W +: W];
        end
    end

    // Next-state logic: grant in IDLE, count words in XFER, close the packet on its last word.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_idx;
        last_nxt      = last_grant;
        word_cnt_nxt  = word_cnt;
        pkt_count_nxt = pkt_count;
        case (state)
            IDLE: begin
                if (enable && pick_found) begin
                    grant_nxt = pick_idx;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (xfer) begin
                    if (word_cnt == LAST_WORD) begin
                        word_cnt_nxt  = '0;
                        last_nxt      = grant_idx;
                        pkt_count_nxt = pkt_count + 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and counters. Synchronous reset abandons any partial packet.
    always_ff @(posedge M_AXIS_ACLK) begin
        // NOTE: registers use non-blocking assignments. Every flop then sees the pre-edge
        // value of every other flop, whatever order the blocks are evaluated in.
        if (!M_AXIS_ARESETN) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= LAST_CORE;
            word_cnt   <= '0;
            pkt_count  <= '0;
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_nxt;
            last_grant <= last_nxt;
            word_cnt   <= word_cnt_nxt;
            pkt_count  <= pkt_count_nxt;
        end
    end

endmodule

// File: tb/tb_dtw_result_arbiter.sv
// Testbench for dtw_result_arbiter.
// A packet-level reference model follows the DUT every cycle:
//   - owner:    which core holds the FIFO;
//   - left:     how many words of the current packet remain;
//   - last:     which core completed the most recent packet;
//   - packets:  total completed packets.
// Each core streams the words i*0x100 + n. A word only advances when the model sees it
// consumed, so a lost or duplicated word shows up as a data difference.
// Directed scenarios add hand-computed literal expectations.

module tb_dtw_result_arbiter;

    localparam int NC  = 4;
    localparam int W   = 32;
    localparam int WPP = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              enable;
    logic [NC-1:0]     valid;
    logic [NC*W-1:0]   data;
    logic [NC-1:0]     ready;
    logic              wren;
    logic [W-1:0]      din;
    logic              full;
    logic [1:0]        grant;
    logic              busy;
    logic [15:0]       pkt;

    always #5 clk = ~clk;

    dtw_result_arbiter #(
        .NUM_CORES(NC), .C_S_AXIS_TDATA_WIDTH(W), .WORDS_PER_PACKET(WPP), .PKT_CNT_WIDTH(16)
    ) dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .enable(enable),
        .core_res_valid(valid), .core_res_data(data), .core_res_ready(ready),
        .dtw_fifo_wren(wren), .dtw_fifo_din(din), .dtw_fifo_full(full),
        .grant_idx(grant), .busy(busy), .pkt_count(pkt)
    );

    // Reference model
    bit  m_owned;
    int  m_owner, m_left, m_last, m_packets;
    int  seq [NC];

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 0;
    int  cyc      = 0;
    int  wr_seen  = 0;
    int  din_log [$];
    int  grant_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic int word_of(input int core);
        return core * 256 + seq[core];
    endfunction

    function automatic int next_owner(input logic [NC-1:0] v);
        for (int k = 1; k <= NC; k++)
            if (v[(m_last + k) % NC]) return (m_last + k) % NC;
        return -1;
    endfunction

    task automatic model_reset();
        m_owned = 0; m_owner = 0; m_left = 0; m_last = NC - 1; m_packets = 0;
    endtask

    // One clock cycle with the given inputs.
    // Inputs are applied at the falling edge. Outputs are compared against the model 1ns later.
    // The model then advances on the rising edge.
    task automatic step(input bit en, input logic [NC-1:0] v, input bit f, input bit rn);
        bit exp_wren;
        @(negedge clk);
        enable = en; valid = v; full = f; rstn = rn;
        for (int i = 0; i < NC; i++) data[i*W +: W] = W'(word_of(i));
        #1;
        exp_wren = m_owned && v[m_owner] && !f;
        if (chk_en) begin
            check("ready", 64'(ready), (m_owned && !f) ? 64'(1 << m_owner) : 64'd0);
            check("wren",  64'(wren),  64'(exp_wren));
            check("din",   64'(din),   m_owned ? 64'(word_of(m_owner)) : 64'd0);
            check("busy",  64'(busy),  64'(m_owned));
            check("pkt_count", 64'(pkt), 64'(m_packets % 65536));
            if (m_owned) check("grant_idx", 64'(grant), 64'(m_owner));
        end
        if (wren) begin
            wr_seen++;
            din_log.push_back(int'(din));
        end
        @(posedge clk);
        cyc++;
        if (!rn) begin
            model_reset();
        end else if (!m_owned) begin
            if (en && next_owner(v) >= 0) begin
                m_owned = 1; m_owner = next_owner(v); m_left = WPP;
            end
        end else if (exp_wren) begin
            seq[m_owner]++;
            m_left--;
            if (m_left == 0) begin
                m_owned = 0; m_last = m_owner; m_packets++;
            end
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic fresh_start();
        for (int i = 0; i < NC; i++) seq[i] = 0;
        step(0, '0, 0, 0);
        din_log.delete();
        wr_seen = 0;
    endtask

    initial begin
        rstn = 0; enable = 0; valid = '0; full = 0; data = '0;
        model_reset();
        for (int i = 0; i < NC; i++) seq[i] = 0;
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk_en = 1;

        // Reset state
        settle();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt",  64'(pkt),  64'd0);
        check("rst_ready", 64'(ready), 64'd0);

        // 1: all cores requesting -> grants 0,1,2,3,0
        fresh_start();
        grant_log.delete();
        for (int c = 1; c <= 45; c++) begin
            bit was_busy;
            was_busy = busy;
            step(1, 4'hF, 0, 1);
            settle();
            if (busy && !was_busy) grant_log.push_back(int'(grant));
            if (c == 36) check("t1_pkt36", 64'(pkt), 64'd4);
        end
        check("t1_pkt45", 64'(pkt), 64'd5);
        check("t1_writes", 64'(wr_seen), 64'd40);
        check("t1_ngrants", 64'(grant_log.size()), 64'd5);
        for (int g = 0; g < grant_log.size() && g < 5; g++)
            check("t1_grant_order", 64'(grant_log[g]), 64'(g % 4));

        // 2: only core 2 -> two back-to-back packets 0x200..0x20F
        fresh_start();
        for (int c = 0; c < 18; c++) step(1, 4'b0100, 0, 1);
        settle();
        check("t2_pkt", 64'(pkt), 64'd2);
        check("t2_nwords", 64'(din_log.size()), 64'd16);
        for (int k = 0; k < din_log.size() && k < 16; k++)
            check("t2_din", 64'(din_log[k]), 64'(32'h200 + k));

        // 3: FIFO full for 3 cycles after word 4 of core 1
        fresh_start();
        for (int c = 0; c < 6; c++) step(1, 4'b0010, 0, 1);
        for (int c = 0; c < 3; c++) begin
            step(1, 4'b0010, 1, 1);
            settle();
            check("t3_ready_full", 64'(ready), 64'd0);
            check("t3_wren_full",  64'(wren),  64'd0);
        end
        for (int c = 0; c < 3; c++) step(1, 4'b0010, 0, 1);
        settle();
        check("t3_pkt", 64'(pkt), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_nwords", 64'(din_log.size()), 64'd8);
        for (int k = 0; k < din_log.size() && k < 8; k++)
            check("t3_din", 64'(din_log[k]), 64'(32'h100 + k));

        // 4: enable dropped mid-packet of core 0
        fresh_start();
        for (int c = 0; c < 4; c++) step(1, 4'hF, 0, 1);
        for (int c = 0; c < 10; c++) step(0, 4'hF, 0, 1);
        settle();
        check("t4_pkt", 64'(pkt), 64'd1);
        check("t4_idle", 64'(busy), 64'd0);
        check("t4_nwords", 64'(wr_seen), 64'd8);
        step(1, 4'hF, 0, 1);
        settle();
        check("t4_regrant_busy", 64'(busy), 64'd1);
        check("t4_regrant_idx", 64'(grant), 64'd1);

        // 5: core 3 drops valid for 10 cycles while cores 0..2 request
        fresh_start();
        for (int c = 0; c < 4; c++) step(1, 4'b1000, 0, 1);
        for (int c = 0; c < 10; c++) begin
            step(1, 4'b0111, 0, 1);
            settle();
            check("t5_no_ready_others", 64'(ready[2:0]), 64'd0);
            check("t5_hold_grant", 64'(grant), 64'd3);
        end
        for (int c = 0; c < 5; c++) step(1, 4'hF, 0, 1);
        settle();
        check("t5_pkt", 64'(pkt), 64'd1);
        step(1, 4'hF, 0, 1);
        settle();
        check("t5_next_grant", 64'(grant), 64'd0);

        // 6: reset after word 5
        fresh_start();
        for (int c = 0; c < 7; c++) step(1, 4'hF, 0, 1);
        step(1, 4'hF, 0, 0);
        settle();
        check("t6_ready", 64'(ready), 64'd0);
        check("t6_wren", 64'(wren), 64'd0);
        check("t6_din", 64'(din), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_pkt", 64'(pkt), 64'd0);
        step(1, 4'hF, 0, 1);
        settle();
        check("t6_first_grant", 64'(grant), 64'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bit rn, en, f;
            rn = ($urandom_range(0, 499) != 0);
            en = ($urandom_range(0, 9) != 0);
            f  = ($urandom_range(0, 4) == 0);
            step(en, 4'($urandom()), f, rn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
